// File: rtl/payload_sched_defs.sv
// Shared definitions for the payload engine scheduler: FSM encodings,
// index-width derivation and default depth/drain settings.
// No ports; imported by payload_engine_sched and match_vec_encode.
package payload_sched_defs;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } sched_state_t;

  localparam int DEF_MAX_DEPTH    = 1500;
  localparam int DEF_DRAIN_CYCLES = 2;

  // Width of an engine index; a single engine still gets a 1-bit field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/match_vec_encode.sv
// Reduces an engine match vector to hit flag, lowest set index and popcount.
// Ports: i_vec (match vector) -> o_hit, o_id (lowest set bit, 0 if none),
//        o_count (number of set bits). Purely combinational.
module match_vec_encode
  import payload_sched_defs::*;
#(
  parameter  int NUM_ENGINES = 32,
  localparam int ID_W        = id_width(NUM_ENGINES)
) (
  input  logic [NUM_ENGINES-1:0] i_vec,
  output logic                   o_hit,
  output logic [ID_W-1:0]        o_id,
  output logic [ID_W:0]          o_count
);

  always_comb begin
    o_hit   = 1'b0;
    o_id    = '0;
    o_count = '0;
    // Walk from the top down so the last write is the lowest set index.
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_hit = 1'b1;
        o_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_ENGINES; i++) begin
      o_count = o_count + {{ID_W{1'b0}}, i_vec[i]};
    end
  end

endmodule

// File: rtl/payload_engine_sched.sv
// Feeds packet payload bytes to a bank of shared-decoder match engines,
// clears them between packets, drains the pipeline, then reports the result.
// Ports: s_* byte stream in (valid/ready), char_out/eng_en/eng_sod to the
//        engines, eng_match sticky vector in, res_* result out (valid/ready).
module payload_engine_sched
  import payload_sched_defs::*;
#(
  parameter  int NUM_ENGINES  = 32,
  parameter  int MAX_DEPTH    = DEF_MAX_DEPTH,
  parameter  int LEN_W        = 16,
  parameter  int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  localparam int ID_W         = id_width(NUM_ENGINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_sop,
  input  logic                   s_eop,
  output logic                   s_ready,
  output logic [7:0]             char_out,
  output logic                   eng_en,
  output logic                   eng_sod,
  input  logic [NUM_ENGINES-1:0] eng_match,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_hit,
  output logic [ID_W-1:0]        res_id,
  output logic [ID_W:0]          res_count,
  output logic [LEN_W-1:0]       res_len,
  output logic                   res_err
);

  localparam int              DC_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);
  localparam logic [LEN_W:0]  DEPTH_L    = (LEN_W + 1)'(MAX_DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;

  sched_state_t     r_state, w_state_nxt;
  logic [7:0]       r_char, w_char_nxt;
  logic             r_en, w_en_nxt;
  logic             r_sod;
  logic             r_s_ready;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic             r_err, w_err_nxt;
  logic [DC_W-1:0]  r_dcnt, w_dcnt_nxt;
  logic             w_capture;
  logic             w_accept;

  logic             r_res_valid;
  logic             r_res_hit;
  logic [ID_W-1:0]  r_res_id;
  logic [ID_W:0]    r_res_count;
  logic [LEN_W-1:0] r_res_len;
  logic             r_res_err;

  logic             w_enc_hit;
  logic [ID_W-1:0]  w_enc_id;
  logic [ID_W:0]    w_enc_count;

  assign w_accept = s_valid & r_s_ready;

  match_vec_encode #(
    .NUM_ENGINES (NUM_ENGINES)
  ) u_encode (
    .i_vec   (eng_match),
    .o_hit   (w_enc_hit),
    .o_id    (w_enc_id),
    .o_count (w_enc_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_char_nxt  = r_char;
    w_en_nxt    = 1'b0;
    w_len_nxt   = r_len;
    w_err_nxt   = r_err;
    w_dcnt_nxt  = r_dcnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // Beats without sop are swallowed so a mid-packet start resyncs.
        if (w_accept && s_sop) begin
          w_char_nxt  = s_data;
          w_en_nxt    = 1'b1;
          w_len_nxt   = LEN_W'(1);
          w_err_nxt   = 1'b0;
          w_dcnt_nxt  = '0;
          w_state_nxt = s_eop ? ST_DRAIN : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_accept) begin
          w_char_nxt = s_data;
          w_len_nxt  = (r_len == LEN_MAX) ? r_len : r_len + LEN_W'(1);
          // Bytes past the scan depth are consumed but never shown to engines.
          w_en_nxt   = ({1'b0, r_len} < DEPTH_L);
          if (s_sop) begin
            w_err_nxt = 1'b1;
          end
          if (s_eop) begin
            w_dcnt_nxt  = '0;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The first drain cycle carries the final eng_en pulse, so the
        // last count lands DRAIN_CYCLES after it.
        if (r_dcnt == DRAIN_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_REPORT;
        end else begin
          w_dcnt_nxt = r_dcnt + DC_W'(1);
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_char      <= '0;
      r_en        <= 1'b0;
      r_sod       <= 1'b1;
      r_s_ready   <= 1'b0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_dcnt      <= '0;
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_id    <= '0;
      r_res_count <= '0;
      r_res_len   <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_char      <= w_char_nxt;
      r_en        <= w_en_nxt;
      r_len       <= w_len_nxt;
      r_err       <= w_err_nxt;
      r_dcnt      <= w_dcnt_nxt;
      // Status outputs are decoded from the next state so they line up
      // with the state register without a combinational path.
      r_sod       <= (w_state_nxt == ST_CLEAR);
      r_s_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_SCAN);
      r_res_valid <= (w_state_nxt == ST_REPORT);
      if (w_capture) begin
        r_res_hit   <= w_enc_hit;
        r_res_id    <= w_enc_id;
        r_res_count <= w_enc_count;
        r_res_len   <= r_len;
        r_res_err   <= r_err;
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign char_out  = r_char;
  assign eng_en    = r_en;
  assign eng_sod   = r_sod;
  assign res_valid = r_res_valid;
  assign res_hit   = r_res_hit;
  assign res_id    = r_res_id;
  assign res_count = r_res_count;
  assign res_len   = r_res_len;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_payload_engine_sched.sv
// Scoreboard bench for payload_engine_sched: drives packets, predicts the
// byte stream seen by the engines and the per-packet result record.
module tb_payload_engine_sched;

  localparam int MAXD = 1500;
  localparam int DRN  = 2;

  typedef struct {
    logic        hit;
    logic [4:0]  id;
    logic [5:0]  cnt;
    logic [15:0] len;
    logic        err;
    bit          scanned;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_sop = 1'b0;
  logic        s_eop = 1'b0;
  logic        s_ready;
  logic [7:0]  char_out;
  logic        eng_en;
  logic        eng_sod;
  logic [31:0] eng_match = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_hit;
  logic [4:0]  res_id;
  logic [5:0]  res_count;
  logic [15:0] res_len;
  logic        res_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_en_cyc = 0;
  int en_total = 0;
  bit prev_valid = 1'b0;
  bit sod_expect = 1'b0;

  logic [7:0] char_q[$];
  exp_t       res_q[$];

  always #5 clk = ~clk;

  payload_engine_sched dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_sop     (s_sop),
    .s_eop     (s_eop),
    .s_ready   (s_ready),
    .char_out  (char_out),
    .eng_en    (eng_en),
    .eng_sod   (eng_sod),
    .eng_match (eng_match),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hit   (res_hit),
    .res_id    (res_id),
    .res_count (res_count),
    .res_len   (res_len),
    .res_err   (res_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      cyc++;
      if (eng_en) begin
        en_total++;
        last_en_cyc = cyc;
        chk("sod_during_en", {31'd0, eng_sod}, 32'd0);
        if (char_q.size() == 0) chk("en_unexpected", 32'd1, 32'd0);
        else chk("char_out", {24'd0, char_out}, {24'd0, char_q.pop_front()});
      end
      if (sod_expect) begin
        chk("sod_after_hs", {31'd0, eng_sod}, 32'd1);
        chk("rdy_in_clear", {31'd0, s_ready}, 32'd0);
        sod_expect = 1'b0;
      end
      if (res_valid) begin
        if (res_q.size() == 0) begin
          chk("res_unexpected", 32'd1, 32'd0);
        end else begin
          if (!prev_valid) begin
            if (res_q[0].scanned) chk("res_latency", cyc - last_en_cyc, DRN);
            chk("en_count_left", char_q.size(), 32'd0);
          end
          chk("res_hit",   {31'd0, res_hit},   {31'd0, res_q[0].hit});
          chk("res_id",    {27'd0, res_id},    {27'd0, res_q[0].id});
          chk("res_count", {26'd0, res_count}, {26'd0, res_q[0].cnt});
          chk("res_len",   {16'd0, res_len},   {16'd0, res_q[0].len});
          chk("res_err",   {31'd0, res_err},   {31'd0, res_q[0].err});
          chk("rdy_in_report", {31'd0, s_ready}, 32'd0);
          if (res_ready) begin
            void'(res_q.pop_front());
            sod_expect = 1'b1;
          end
        end
      end
      prev_valid = res_valid;
    end else begin
      prev_valid = 1'b0;
      sod_expect = 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop, output bit ok);
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    s_eop   = eop;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("rdy_timeout", 32'd0, 32'd1);
    else @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt(input int n, input int sop_at, input logic [31:0] m, input bit eop);
    exp_t e;
    bit   ok;
    wait_idle();
    eng_match = m;
    for (int i = 0; i < n; i++) begin
      send_beat(8'h41 + 8'(i), (i == 0) || (i == sop_at), eop && (i == n - 1), ok);
      if (ok && i < MAXD) char_q.push_back(8'h41 + 8'(i));
    end
    if (eop) begin
      e.hit = |m;
      e.id  = '0;
      for (int j = 31; j >= 0; j--) if (m[j]) e.id = 5'(j);
      e.cnt = 6'($countones(m));
      e.len = 16'(n);
      e.err = (sop_at > 0) && (sop_at < n);
      e.scanned = (n <= MAXD);
      res_q.push_back(e);
    end
  endtask

  task automatic wait_results();
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (res_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("result_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int en_before;
    bit seen;

    // Reset state and release.
    repeat (3) @(negedge clk);
    chk("rst_sod",   {31'd0, eng_sod},   32'd1);
    chk("rst_en",    {31'd0, eng_en},    32'd0);
    chk("rst_ready", {31'd0, s_ready},   32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_len",   {16'd0, res_len},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_sod",   {31'd0, eng_sod},   32'd0);
    chk("rel_ready", {31'd0, s_ready},   32'd1);
    chk("rel_valid", {31'd0, res_valid}, 32'd0);

    // "ABCDE", no match.
    send_pkt(5, -1, 32'h0000_0000, 1'b1);
    wait_results();

    // Two engines hit.
    send_pkt(3, -1, 32'h0000_0120, 1'b1);
    wait_results();

    // Oversized packet: only the first MAXD bytes are scanned.
    en_before = en_total;
    send_pkt(1600, -1, 32'h8000_0001, 1'b1);
    wait_results();
    chk("depth_en_pulses", en_total - en_before, MAXD);

    // Single-byte packet held in REPORT.
    res_ready = 1'b0;
    send_pkt(1, -1, 32'hFFFF_FFFF, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("single_valid", {31'd0, seen}, 32'd1);
    repeat (10) @(negedge clk);
    res_ready = 1'b1;
    wait_results();

    // Stray beat in IDLE is dropped; then sop appears mid-packet.
    wait_idle();
    send_beat(8'h5A, 1'b0, 1'b0, ok);
    @(negedge clk);
    chk("drop_ready", {31'd0, s_ready}, 32'd1);
    send_pkt(4, 2, 32'h8000_0000, 1'b1);
    wait_results();

    // Reset in SCAN abandons the packet.
    send_pkt(3, -1, 32'h0000_0004, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_scan_sod",   {31'd0, eng_sod}, 32'd1);
    chk("rst_scan_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_scan_q",     char_q.size(),    32'd0);
    @(negedge clk);
    chk("rst_scan_idle",  {31'd0, s_ready}, 32'd1);
    send_pkt(7, -1, 32'h0000_0004, 1'b1);
    wait_results();

    repeat (5) @(negedge clk);
    chk("final_char_q", char_q.size(), 32'd0);
    chk("final_res_q",  res_q.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/payload_engine_sched.md
Name: payload_engine_sched

Overview:
- Sequences packet payload bytes into a bank of NUM_ENGINES parallel PCRE match engines that share one character decoder.
- Gates the engines' enable, pulses their start-of-data clear between packets, waits for the pipeline to drain, then samples the sticky match vector.
- Reports per-packet results through a valid/ready handshake.
- Sits between the payload extractor and the rule-hit reporting logic.

Parameters:
- NUM_ENGINES, 32, number of engine match outputs sampled.
- MAX_DEPTH, 1500, bytes per packet fed to the engines; later bytes are consumed but not scanned.
- LEN_W, 16, width of the packet byte counter.
- DRAIN_CYCLES, 2, cycles from the last enabled byte to a stable match vector (decoder plus engine flop latency).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_data  in  8  payload byte
- s_valid  in  1  byte valid
- s_sop  in  1  first byte of packet
- s_eop  in  1  last byte of packet
- s_ready  out  1  byte accepted when s_valid & s_ready
- char_out  out  8  registered byte driven to the shared character decoder
- eng_en  out  1  engine clock-enable; high for exactly one cycle per scanned byte
- eng_sod  out  1  engine clear (start of data)
- eng_match  in  NUM_ENGINES  sticky engine outputs
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_hit  out  1  any engine matched
- res_id  out  ID_W  lowest matching engine index (0 if none); ID_W = clog2(NUM_ENGINES)
- res_count  out  ID_W+1  number of matching engines
- res_len  out  LEN_W  bytes accepted in the packet
- res_err  out  1  protocol error seen in the packet

Behaviour:
- Single clock domain. rst is synchronous and active-high. All outputs are registered.
- On rst: state = CLEAR, eng_sod = 1, eng_en = 0, s_ready = 0, res_valid = 0, all result fields = 0, counters = 0.
- FSM states: CLEAR, IDLE, SCAN, DRAIN, REPORT.
- CLEAR:
  - eng_sod = 1 for exactly one cycle; s_ready = 0.
  - Next state IDLE.
- IDLE:
  - s_ready = 1.
  - Accepted beat without s_sop: dropped. No eng_en, no state change.
  - Accepted beat with s_sop: char_out <= s_data; eng_en = 1 in the next cycle; len = 1; err = 0.
  - Next state is DRAIN if s_eop is also set, otherwise SCAN.
- SCAN:
  - s_ready = 1.
  - Each accepted beat: char_out <= s_data; len increments, saturating at 2^LEN_W-1.
  - eng_en = 1 in the next cycle only if the pre-increment len < MAX_DEPTH.
  - No accepted beat: eng_en = 0 (engines hold state).
  - Accepted beat with s_sop: treated as an ordinary byte; err = 1.
  - Accepted beat with s_eop: next state DRAIN.
- DRAIN:
  - s_ready = 0, eng_en = 0.
  - Counts DRAIN_CYCLES cycles starting after the last eng_en pulse.
  - On the final count, captures eng_match into res_hit / res_id / res_count, and len / err into res_len / res_err.
  - Next state REPORT.
- REPORT:
  - res_valid = 1; result fields are held stable.
  - Stays until res_valid & res_ready, then res_valid = 0 and next state CLEAR.
- Minimum per-packet overhead after the eop beat: DRAIN_CYCLES + 2 cycles (REPORT with res_ready already high, then CLEAR).
- eng_sod and eng_en are never high in the same cycle.
- rst asserted mid-packet or mid-REPORT: the packet is abandoned, no result is emitted, and the FSM restarts at CLEAR.
- res_id tie rule: the lowest set index wins. res_count is the popcount of the captured vector.

Decomposition:
- Shared package/include payload_sched_defs holds:
  - state encodings: CLEAR=0, IDLE=1, SCAN=2, DRAIN=3, REPORT=4;
  - the clog2-based ID_W derivation;
  - MAX_DEPTH and DRAIN_CYCLES defaults.
- One sub-module, match_vec_encode: combinational, NUM_ENGINES-parameterised; produces hit, lowest index and popcount from the match vector; instantiated once at the capture point.

Test Plan:
- Reset release -> eng_sod = 1 for exactly one cycle, then s_ready = 1; res_valid stays 0.
- 5-byte packet "ABCDE" (sop on A, eop on E), eng_match = 32'h0000_0000, res_ready = 1:
  - eng_en pulses 5 times with char_out = 41..45;
  - res_valid rises DRAIN_CYCLES cycles after the last eng_en, with res_hit = 0, res_len = 5, res_err = 0;
  - eng_sod pulses on the cycle after the handshake.
- Packet with eng_match = 32'h0000_0120 at sample time -> res_hit = 1, res_id = 5, res_count = 2.
- 1600-byte packet with MAX_DEPTH = 1500 -> exactly 1500 eng_en pulses, all 1600 beats accepted, res_len = 1600.
- Single-byte packet (sop & eop on the same beat), res_ready held 0 for 10 cycles -> result fields stable and s_ready = 0 throughout; CLEAR follows the handshake.
- Beat without sop in IDLE -> dropped, no eng_en. sop mid-packet -> res_err = 1.
- rst in SCAN -> no result emitted, eng_sod pulses, next packet reports a correct res_len.
